// File: rtl/ila_window_capture.sv
// ILA capture engine: circular sample buffer holding a programmable pre/post-trigger window
// around a per-bit value/edge trigger, with an oldest-first logical read port.
module ila_window_capture #(
    parameter int unsigned SIGNAL_W  = 32,
    parameter int unsigned TRIGGER_W = 8,
    parameter int unsigned BUFFER_W  = 10,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned NWORDS   = (SIGNAL_W + DATA_W - 1) / DATA_W,
    localparam int unsigned SEL_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [SIGNAL_W-1:0]  signal_i,
    input  logic [TRIGGER_W-1:0] trigger_i,
    input  logic [TRIGGER_W-1:0] trig_mask_i,
    input  logic [TRIGGER_W-1:0] trig_value_i,
    input  logic [TRIGGER_W-1:0] trig_edge_i,
    input  logic                 reduce_and_i,
    input  logic                 qualify_i,
    input  logic [BUFFER_W-1:0]  pre_depth_i,
    input  logic [BUFFER_W-1:0]  post_depth_i,
    input  logic [BUFFER_W-1:0]  rd_index_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic [2:0]           state_o,
    output logic                 done_o,
    output logic                 trig_valid_o,
    output logic [BUFFER_W-1:0]  trig_pos_o,
    output logic [BUFFER_W:0]    n_samples_o
);

    localparam int unsigned DEPTH = 1 << BUFFER_W;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StArmed = 3'd2,
        StPost  = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [SIGNAL_W-1:0]   sig_q;
    logic [TRIGGER_W-1:0]  trig_q;
    logic                  qual_q;
    logic [TRIGGER_W-1:0]  match_prev_q;
    logic [BUFFER_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BUFFER_W-1:0]   start_ptr_q, start_ptr_d;
    logic [BUFFER_W:0]     count_q, count_d;
    logic [BUFFER_W-1:0]   remain_q, remain_d;
    logic [BUFFER_W-1:0]   pre_q, pre_d;
    logic [BUFFER_W-1:0]   post_q, post_d;
    logic                  trig_valid_q, trig_valid_d;
    logic [BUFFER_W-1:0]   trig_pos_q, trig_pos_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;

    logic [SIGNAL_W-1:0]   mem [DEPTH];
    logic                  wr_en;

    // Trigger evaluation on the registered inputs
    logic [TRIGGER_W-1:0]  match, fire;
    logic                  hit;

    always_comb begin
        match = ~(trig_q ^ trig_value_i);
        fire  = match & ~(trig_edge_i & match_prev_q);
        if (reduce_and_i) begin
            hit = &(fire | ~trig_mask_i);
        end else begin
            hit = |(fire & trig_mask_i);
        end
        hit = hit & (|trig_mask_i);
    end

    // Post window clamped so pre + trigger + post never exceeds the buffer
    logic [BUFFER_W-1:0] room, post_eff;

    always_comb begin
        room     = {BUFFER_W{1'b1}} - pre_depth_i;
        post_eff = (post_depth_i < room) ? post_depth_i : room;
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        count_d      = count_q;
        remain_d     = remain_q;
        pre_d        = pre_q;
        post_d       = post_q;
        trig_valid_d = trig_valid_q;
        trig_pos_d   = trig_pos_q;
        wr_en        = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (arm_i && !abort_i) begin
                    wr_ptr_d     = '0;
                    start_ptr_d  = '0;
                    count_d      = '0;
                    trig_valid_d = 1'b0;
                    pre_d        = pre_depth_i;
                    post_d       = post_eff;
                    state_d      = (pre_depth_i == '0) ? StArmed : StFill;
                end
            end
            StFill: begin
                if (abort_i) begin
                    state_d = StDone;
                end else if (qual_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + (BUFFER_W + 1)'(1);
                    if (count_d == {1'b0, pre_q}) begin
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (abort_i) begin
                    state_d = StDone;
                end else if (hit) begin
                    wr_en        = 1'b1;
                    trig_pos_d   = count_q[BUFFER_W-1:0];
                    trig_valid_d = 1'b1;
                    count_d      = count_q + (BUFFER_W + 1)'(1);
                    remain_d     = post_q;
                    state_d      = (post_q == '0) ? StDone : StPost;
                end else if (qual_q) begin
                    wr_en = 1'b1;
                    // Pre-window full: drop the oldest sample instead of growing
                    if (count_q == {1'b0, pre_q}) begin
                        start_ptr_d = start_ptr_q + BUFFER_W'(1);
                    end else begin
                        count_d = count_q + (BUFFER_W + 1)'(1);
                    end
                end
            end
            StPost: begin
                if (abort_i) begin
                    state_d = StDone;
                end else if (qual_q) begin
                    wr_en    = 1'b1;
                    count_d  = count_q + (BUFFER_W + 1)'(1);
                    remain_d = remain_q - BUFFER_W'(1);
                    if (remain_q == BUFFER_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + BUFFER_W'(1);
        end
    end

    // Logical read: zero-pad the sample and pick one DATA_W slice
    logic [BUFFER_W-1:0]       rd_addr;
    logic [NWORDS*DATA_W-1:0]  padded;

    always_comb begin
        rd_addr                = start_ptr_q + rd_index_i;
        padded                 = '0;
        padded[SIGNAL_W-1:0]   = mem[rd_addr];
        rd_data_d              = '0;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (rd_sel_i == SEL_W'(w)) begin
                rd_data_d = padded[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i && wr_en) begin
            mem[wr_ptr_q] <= sig_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= StIdle;
            sig_q        <= '0;
            trig_q       <= '0;
            qual_q       <= 1'b0;
            match_prev_q <= '0;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            trig_valid_q <= 1'b0;
            trig_pos_q   <= '0;
            rd_data_q    <= '0;
        end else if (cke_i) begin
            state_q      <= state_d;
            sig_q        <= signal_i;
            trig_q       <= trigger_i;
            qual_q       <= qualify_i;
            match_prev_q <= match;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            count_q      <= count_d;
            remain_q     <= remain_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            trig_valid_q <= trig_valid_d;
            trig_pos_q   <= trig_pos_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign state_o      = state_q;
    assign done_o       = (state_q == StDone);
    assign trig_valid_o = trig_valid_q;
    assign trig_pos_o   = trig_pos_q;
    assign n_samples_o  = count_q;
    assign rd_data_o    = rd_data_q;

endmodule
